// File: rtl/stack_pointer_bank.sv
// Bank of NUM_STACKS independent hardware stack pointers with per-stack occupancy
// counters, bounds protection, direct context-switch load and sticky error flags.

module stack_pointer_lane #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int STEP  = 2,
  parameter int BASE  = 32'h7FFE,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             op,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             flag_clear,
  output logic [WIDTH-1:0] ptr,
  output logic [CNT_W-1:0] cnt,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             load_err
);
  localparam logic [WIDTH-1:0] BASE_W  = WIDTH'(BASE);
  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(BASE - DEPTH * STEP);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_M = WIDTH'(STEP - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam int               SHIFT   = $clog2(STEP);

  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] load_cnt;
  logic             load_ok, do_push, do_pop;
  logic             set_ovf, set_unf, set_lerr;

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);

  // Distance below base doubles as alignment check and entry count.
  assign diff     = BASE_W - load_val;
  assign load_ok  = (load_val >= LIMIT_W) && (load_val <= BASE_W) && ((diff & ALIGN_M) == '0);
  assign load_cnt = CNT_W'(diff >> SHIFT);

  assign do_push  = !load_en && write && !op;
  assign do_pop   = !load_en && write && op;
  assign set_ovf  = do_push && full;
  assign set_unf  = do_pop && empty;
  assign set_lerr = load_en && !load_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= BASE_W;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (load_en) begin
        if (load_ok) begin
          ptr <= load_val;
          cnt <= load_cnt;
        end
      end else if (do_push && !full) begin
        ptr <= ptr - STEP_W;
        cnt <= cnt + CNT_W'(1);
      end else if (do_pop && !empty) begin
        ptr <= ptr + STEP_W;
        cnt <= cnt - CNT_W'(1);
      end
      // Set beats clear when both land in the same cycle.
      overflow  <= set_ovf  | (overflow  & ~flag_clear);
      underflow <= set_unf  | (underflow & ~flag_clear);
      load_err  <= set_lerr | (load_err  & ~flag_clear);
    end
  end
endmodule

module stack_pointer_bank #(
  parameter int               WIDTH      = 16,
  parameter int               NUM_STACKS = 2,
  parameter int               DEPTH      = 256,
  parameter int               STEP       = 2,
  parameter logic [WIDTH-1:0] TOP_ADDR   = 16'h7FFE,
  localparam int              CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                          CLK,
  input  logic                          RegReset,
  input  logic [NUM_STACKS-1:0]         Write,
  input  logic [NUM_STACKS-1:0]         Op,
  input  logic [NUM_STACKS-1:0]         LoadEn,
  input  logic [NUM_STACKS*WIDTH-1:0]   LoadVal,
  input  logic [NUM_STACKS-1:0]         FlagClear,
  output logic [NUM_STACKS*WIDTH-1:0]   PtrOut,
  output logic [NUM_STACKS*CNT_W-1:0]   CountOut,
  output logic [NUM_STACKS-1:0]         Empty,
  output logic [NUM_STACKS-1:0]         Full,
  output logic [NUM_STACKS-1:0]         Overflow,
  output logic [NUM_STACKS-1:0]         Underflow,
  output logic [NUM_STACKS-1:0]         LoadErr
);
  // Stacks are laid out downward from TOP_ADDR; the lowest limit must not go negative.
  if (int'(TOP_ADDR) - NUM_STACKS * DEPTH * STEP < 0) begin : g_bad_range
    $error("stack_pointer_bank: lowest stack limit below address 0");
  end
  if (DEPTH < 1 || NUM_STACKS < 1 || STEP < 1 || (STEP & (STEP - 1)) != 0) begin : g_bad_param
    $error("stack_pointer_bank: illegal DEPTH/NUM_STACKS/STEP");
  end

  for (genvar i = 0; i < NUM_STACKS; i++) begin : g_stack
    stack_pointer_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .STEP  (STEP),
      .BASE  (int'(TOP_ADDR) - i * DEPTH * STEP),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk        (CLK),
      .rst        (RegReset),
      .write      (Write[i]),
      .op         (Op[i]),
      .load_en    (LoadEn[i]),
      .load_val   (LoadVal[i*WIDTH +: WIDTH]),
      .flag_clear (FlagClear[i]),
      .ptr        (PtrOut[i*WIDTH +: WIDTH]),
      .cnt        (CountOut[i*CNT_W +: CNT_W]),
      .empty      (Empty[i]),
      .full       (Full[i]),
      .overflow   (Overflow[i]),
      .underflow  (Underflow[i]),
      .load_err   (LoadErr[i])
    );
  end
endmodule

// File: tb/tb_stack_pointer_bank.sv
// Directed vector table for the documented corner cases, then randomized
// commands checked against a count-based reference model.

module tb_stack_pointer_bank;
  localparam int          W   = 16;
  localparam int          N   = 2;
  localparam int          D   = 4;
  localparam int          S   = 2;
  localparam logic [15:0] TOP = 16'h0100;

  logic        CLK = 1'b0;
  logic        RegReset;
  logic [1:0]  Write, Op, LoadEn, FlagClear;
  logic [31:0] LoadVal, PtrOut;
  logic [5:0]  CountOut;
  logic [1:0]  Empty, Full, Overflow, Underflow, LoadErr;

  always #5 CLK = ~CLK;

  stack_pointer_bank #(
    .WIDTH(W), .NUM_STACKS(N), .DEPTH(D), .STEP(S), .TOP_ADDR(TOP)
  ) dut (
    .CLK(CLK), .RegReset(RegReset), .Write(Write), .Op(Op), .LoadEn(LoadEn),
    .LoadVal(LoadVal), .FlagClear(FlagClear), .PtrOut(PtrOut), .CountOut(CountOut),
    .Empty(Empty), .Full(Full), .Overflow(Overflow), .Underflow(Underflow),
    .LoadErr(LoadErr)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  wr, op, ld, clr;
    logic [15:0] lv0, lv1;
    logic [15:0] p0, p1;
    logic [2:0]  c0, c1;
    logic [1:0]  emp, full, ovf, unf, lerr;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pointer is always base - count*STEP, so only count is kept.
  int m_cnt[N];
  bit m_ovf[N], m_unf[N], m_lerr[N];

  function automatic int base_of(int s);
    return int'(TOP) - s * D * S;
  endfunction

  function automatic vec_t mk(logic rst, logic [1:0] wr, logic [1:0] op, logic [1:0] ld,
                              logic [15:0] lv0, logic [15:0] lv1, logic [1:0] clr,
                              logic [15:0] p0, logic [15:0] p1, logic [2:0] c0, logic [2:0] c1,
                              logic [1:0] emp, logic [1:0] full, logic [1:0] ovf,
                              logic [1:0] unf, logic [1:0] lerr);
    vec_t v;
    v.rst = rst; v.wr = wr; v.op = op; v.ld = ld; v.lv0 = lv0; v.lv1 = lv1; v.clr = clr;
    v.p0 = p0; v.p1 = p1; v.c0 = c0; v.c1 = c1;
    v.emp = emp; v.full = full; v.ovf = ovf; v.unf = unf; v.lerr = lerr;
    return v;
  endfunction

  task automatic compare(string name, logic [47:0] exp);
    logic [47:0] act;
    act = {PtrOut, CountOut, Empty, Full, Overflow, Underflow, LoadErr};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ptr=%h cnt=%b flags=%b, expected ptr=%h cnt=%b flags=%b",
               name, act[47:16], act[15:10], act[9:0], exp[47:16], exp[15:10], exp[9:0]);
    end
  endtask

  task automatic model_step();
    for (int s = 0; s < N; s++) begin
      int  b, v;
      bit  so, su, sl;
      b = base_of(s);
      v = int'(LoadVal[s*16 +: 16]);
      so = 0; su = 0; sl = 0;
      if (RegReset) begin
        m_cnt[s] = 0; m_ovf[s] = 0; m_unf[s] = 0; m_lerr[s] = 0;
      end else begin
        if (LoadEn[s]) begin
          if (v <= b && v >= b - D * S && (b - v) % S == 0) m_cnt[s] = (b - v) / S;
          else sl = 1;
        end else if (Write[s]) begin
          if (!Op[s]) begin
            if (m_cnt[s] == D) so = 1; else m_cnt[s]++;
          end else begin
            if (m_cnt[s] == 0) su = 1; else m_cnt[s]--;
          end
        end
        m_ovf[s]  = so | (m_ovf[s]  & !FlagClear[s]);
        m_unf[s]  = su | (m_unf[s]  & !FlagClear[s]);
        m_lerr[s] = sl | (m_lerr[s] & !FlagClear[s]);
      end
    end
  endtask

  function automatic logic [47:0] model_pack();
    logic [31:0] p;
    logic [5:0]  c;
    logic [1:0]  e, f, o, u, l;
    for (int s = 0; s < N; s++) begin
      p[s*16 +: 16] = 16'(base_of(s) - m_cnt[s] * S);
      c[s*3 +: 3]   = 3'(m_cnt[s]);
      e[s] = (m_cnt[s] == 0);
      f[s] = (m_cnt[s] == D);
      o[s] = m_ovf[s]; u[s] = m_unf[s]; l[s] = m_lerr[s];
    end
    return {p, c, e, f, o, u, l};
  endfunction

  vec_t tbl[$];

  initial begin
    RegReset = 1'b0; Write = '0; Op = '0; LoadEn = '0; LoadVal = '0; FlagClear = '0;

    //               rst wr     op     ld     lv0     lv1     clr    p0      p1      c0 c1 emp    full   ovf    unf    lerr
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'h100, 16'hF8, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'hFE,  16'hF8, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'hFC,  16'hF8, 2, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'hFA,  16'hF8, 3, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'hF8,  16'hF8, 4, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'hF8,  16'hF8, 4, 0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b10, 2'b10, 2'b00, 16'h0, 16'h0, 2'b00, 16'hF8,  16'hF8, 4, 0, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00));
    tbl.push_back(mk(0, 2'b10, 2'b10, 2'b00, 16'h0, 16'h0, 2'b10, 16'hF8,  16'hF8, 4, 0, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 2'b10, 16'hF8,  16'hF8, 4, 0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b01, 2'b01, 2'b00, 16'h0, 16'h0, 2'b00, 16'hFA,  16'hF8, 3, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'h100, 16'hF8, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'hFE,  16'hF6, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'hFE,  16'hF4, 1, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 16'h0, 16'h0, 2'b00, 16'hFC,  16'hF6, 2, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b10, 16'h0, 16'hF2, 2'b00, 16'hFC,  16'hF2, 2, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b10, 16'h0, 16'hF3, 2'b00, 16'hFC,  16'hF2, 2, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b10, 16'h0, 16'hEE, 2'b00, 16'hFC,  16'hF2, 2, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 2'b10, 16'hFC,  16'hF2, 2, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b10, 16'h0, 16'hF0, 2'b00, 16'hFC,  16'hF0, 2, 4, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b10, 2'b10, 2'b10, 16'h0, 16'hF8, 2'b00, 16'hFC,  16'hF8, 2, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b01, 16'h102, 16'h0, 2'b00, 16'hFC, 16'hF8, 2, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b01, 16'hF8, 16'h0, 2'b00, 16'hF8,  16'hF8, 4, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01));

    foreach (tbl[i]) begin
      RegReset = tbl[i].rst; Write = tbl[i].wr; Op = tbl[i].op; LoadEn = tbl[i].ld;
      LoadVal = {tbl[i].lv1, tbl[i].lv0}; FlagClear = tbl[i].clr;
      @(posedge CLK); #1;
      compare($sformatf("vec%0d", i),
              {tbl[i].p1, tbl[i].p0, tbl[i].c1, tbl[i].c0, tbl[i].emp, tbl[i].full,
               tbl[i].ovf, tbl[i].unf, tbl[i].lerr});
    end

    // Random phase starts from a reset so the model is in step with the DUT.
    for (int k = 0; k < 500; k++) begin
      RegReset  = (k == 0) || ($urandom_range(0, 59) == 0);
      Write     = 2'($urandom);
      Op        = 2'($urandom);
      LoadEn    = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      FlagClear = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      for (int s = 0; s < N; s++) begin
        int v;
        v = base_of(s) + S - int'($urandom_range(0, 6)) * S + (($urandom_range(0, 3) == 0) ? 1 : 0);
        LoadVal[s*16 +: 16] = 16'(v);
      end
      model_step();
      @(posedge CLK); #1;
      compare($sformatf("rand%0d", k), model_pack());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_pointer_bank.md
# stack_pointer_bank

Parametrised bank of independent hardware stack pointers for the 16-bit datapath. It generalises the fixed MSP/RSP incrementer pair into NUM_STACKS pointers that all update in the same cycle, each with its own occupancy counter. Each pointer adds bounds protection, direct load for context switch, and sticky error flags. It sits in stage 1 and feeds the memory-access stage destination muxes exactly as the dedicated stack pointers do.

## Interface
Parameters:
- WIDTH, 16, pointer/address width
- NUM_STACKS, 2, number of independent stacks (>=1)
- DEPTH, 256, maximum entries per stack (>=1)
- STEP, 2, address increment per entry; power of two
- TOP_ADDR, 16'h7FFE, base (empty) pointer of stack 0
- Derived: CNT_W = clog2(DEPTH+1); base of stack i = TOP_ADDR - i*DEPTH*STEP; limit of stack i = base_i - DEPTH*STEP

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RegReset  in  1  synchronous, active-high reset
- Write  in  NUM_STACKS  per-stack push/pop enable
- Op  in  NUM_STACKS  per-stack operation: 0 = push (pointer -= STEP), 1 = pop (pointer += STEP)
- LoadEn  in  NUM_STACKS  per-stack direct pointer load
- LoadVal  in  NUM_STACKS*WIDTH  load values, stack i at bits [i*WIDTH +: WIDTH]
- FlagClear  in  NUM_STACKS  per-stack clear of sticky flags
- PtrOut  out  NUM_STACKS*WIDTH  current pointers, same packing as LoadVal
- CountOut  out  NUM_STACKS*CNT_W  current entry counts
- Empty  out  NUM_STACKS  count == 0
- Full  out  NUM_STACKS  count == DEPTH
- Overflow  out  NUM_STACKS  sticky: push attempted while full
- Underflow  out  NUM_STACKS  sticky: pop attempted while empty
- LoadErr  out  NUM_STACKS  sticky: rejected load

## Operation
- Pointer holds the address of the current top entry. Empty pointer == base_i. First push yields base_i - STEP.
- Per stack, priority: RegReset > LoadEn > Write. Stacks are fully independent and any subset may act in one cycle.
- Reset: pointer_i = base_i, count = 0, all sticky flags = 0. Outputs follow: Empty = all 1s, Full = 0 (or all 1s only if DEPTH==0, which is disallowed).
- Push, not full: pointer -= STEP, count += 1. Push, full: pointer and count hold, Overflow set.
- Pop, not empty: pointer += STEP, count -= 1. Pop, empty: pointer and count hold, Underflow set.
- Load is valid if LoadVal is STEP-aligned relative to base_i and limit_i <= LoadVal <= base_i. A valid load sets pointer = LoadVal and count = (base_i - LoadVal)/STEP, computed as a shift by log2(STEP).
- An invalid load holds pointer and count and sets LoadErr. Write is ignored in any cycle with LoadEn.
- FlagClear clears all three sticky flags of that stack. If a set event occurs in the same cycle, set wins.
- Arithmetic is WIDTH-bit unsigned. Bounds are enforced by count, so the pointer never wraps. The TOP_ADDR/DEPTH/NUM_STACKS combination must keep the lowest limit >= 0; this is an elaboration-time check.

## Timing
- All state is registered. PtrOut, CountOut and the flags change only on the CLK edge that samples the command, so they are visible in the next cycle. Latency is one cycle and there are no stalls.
- Empty and Full are combinational decodes of the registered count, with no extra latency.
- Back-to-back commands every cycle are supported. Push then pop on consecutive cycles returns the pointer to its prior value.
- RegReset asserted mid-sequence overrides all commands in that cycle. The post-reset state is visible on the next cycle.

## Test plan
Configuration for all cases: WIDTH=16, NUM_STACKS=2, DEPTH=4, STEP=2, TOP_ADDR=16'h0100. Base0=0x0100, base1=0x00F8, limit1=0x00F0.
- Reset: hold RegReset 1 cycle -> Ptr0=0x0100, Ptr1=0x00F8, counts 0, Empty=2'b11, Full=0, all flags 0.
- Overflow: 5 consecutive pushes on stack 0 -> Ptr0 goes 0x00FE, 0x00FC, 0x00FA, 0x00F8; Full[0]=1 after the 4th push. The 5th push leaves Ptr0=0x00F8 and sets Overflow[0]=1. Stack 1 is unchanged.
- Underflow and clear: pop stack 1 while empty -> Ptr1=0x00F8 and Underflow[1]=1. Then FlagClear[1] together with another empty pop -> Underflow[1] stays 1 (set wins). FlagClear[1] alone -> 0.
- Concurrency: stack 1 at count 2 (Ptr1=0x00F4); same cycle push stack 0 (from count 1) and pop stack 1 -> next cycle Ptr0=0x00FC, Ptr1=0x00F6, counts 2 and 1.
- Load: LoadVal1=0x00F2 -> Ptr1=0x00F2, count 3. LoadVal1=0x00F3 -> rejected, LoadErr[1]=1. LoadVal1=0x00EE -> rejected. LoadEn together with Write -> load applied, push ignored.
- Reset mid-operation: stack 0 at count 3 with Overflow[0]=1; assert RegReset in the same cycle as a push -> Ptr0=0x0100, count 0, Overflow[0]=0.
